// File: rtl/dpb_bank_scheduler.sv
// Ring-order bank allocator for the DPB RAM: grants free banks, queues committed banks and presents one per read (req 2 cycles after commit, held until done).
// Define DPB_SCHED_WDOG_EN to add a read watchdog (RD_TIMEOUT) that force-releases a bank the reader never finishes.
module dpb_bank_scheduler #(
  parameter int BANK_NUM               = 16,
  parameter int UDP_FRAME_MAX_SIZE_128 = 91
`ifdef DPB_SCHED_WDOG_EN
  ,
  parameter int RD_TIMEOUT             = 1000000
`endif
) (
  input  logic       i_pclk,
  input  logic       i_rst,
  input  logic       i_wr_alloc_req,
  output logic       o_wr_alloc_gnt,
  output logic [3:0] o_wr_bank,
  input  logic       i_wr_commit,
  input  logic [6:0] i_wr_commit_128cnt,
  input  logic [5:0] i_wr_commit_bytecnt,
  input  logic       i_wr_commit_last,
  output logic       o_rd_req,
  output logic [3:0] o_rd_bank,
  output logic [6:0] o_rd_128cnt,
  output logic [5:0] o_rd_bytecnt,
  output logic       o_rd_last,
  output logic [7:0] o_rd_udp_rank,
  input  logic       i_rd_done,
  output logic [4:0] o_used_cnt,
  output logic [7:0] o_frame_cnt,
  output logic       o_error
);

  localparam int PW = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;

  typedef enum logic {W_IDLE, W_FILL} w_state_t;
  typedef enum logic {R_IDLE, R_BUSY} r_state_t;

  w_state_t          r_wst;
  r_state_t          r_rstate;
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [BANK_NUM-1:0] r_q_vld;
  logic [6:0]        r_q_cnt  [BANK_NUM];
  logic [5:0]        r_q_byte [BANK_NUM];
  logic              r_q_last [BANK_NUM];
  logic              r_avail;

  logic w_grant;
  logic w_commit_ok;
  logic w_release;
  logic w_wdog_fire;
  logic w_bad_cnt;
  logic w_rank_sat;
  logic w_proto_err;

`ifdef DPB_SCHED_WDOG_EN
  logic [31:0] r_wdog;
  assign w_wdog_fire = (r_rstate == R_BUSY) && (r_wdog == 32'(RD_TIMEOUT - 1));
`else
  assign w_wdog_fire = 1'b0;
`endif

  // Grant decision uses the registered count only, so a same-cycle release delays the grant by one cycle.
  assign w_grant     = (r_wst == W_IDLE) && i_wr_alloc_req && (o_used_cnt < 5'(BANK_NUM));
  assign w_commit_ok = (r_wst == W_FILL) && i_wr_commit;
  assign w_release   = (r_rstate == R_BUSY) && (i_rd_done || w_wdog_fire);
  assign w_bad_cnt   = i_wr_commit && ((i_wr_commit_128cnt == 7'd0) ||
                       (i_wr_commit_128cnt > 7'(UDP_FRAME_MAX_SIZE_128)));
  assign w_rank_sat  = w_release && !w_wdog_fire && !o_rd_last && (o_rd_udp_rank == 8'hFF);
  assign w_proto_err = (i_wr_commit && (r_wst != W_FILL)) || (i_rd_done && (r_rstate != R_BUSY)) ||
                       w_bad_cnt || w_rank_sat || w_wdog_fire;

  always_ff @(posedge i_pclk) begin
    if (w_commit_ok) begin
      r_q_cnt[r_wr_ptr]  <= i_wr_commit_128cnt;
      r_q_byte[r_wr_ptr] <= i_wr_commit_bytecnt;
      r_q_last[r_wr_ptr] <= i_wr_commit_last;
    end
  end

  always_ff @(posedge i_pclk or posedge i_rst) begin
    if (i_rst) begin
      r_wst          <= W_IDLE;
      r_rstate       <= R_IDLE;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_q_vld        <= '0;
      r_avail        <= 1'b0;
      o_wr_alloc_gnt <= 1'b0;
      o_wr_bank      <= 4'd0;
      o_rd_req       <= 1'b0;
      o_rd_bank      <= 4'd0;
      o_rd_128cnt    <= 7'd0;
      o_rd_bytecnt   <= 6'd0;
      o_rd_last      <= 1'b0;
      o_rd_udp_rank  <= 8'd0;
      o_used_cnt     <= 5'd0;
      o_frame_cnt    <= 8'd0;
      o_error        <= 1'b0;
`ifdef DPB_SCHED_WDOG_EN
      r_wdog         <= 32'd0;
`endif
    end else begin
      o_wr_alloc_gnt <= 1'b0;
      case (r_wst)
        W_IDLE: if (w_grant) begin
          o_wr_alloc_gnt <= 1'b1;
          o_wr_bank      <= 4'(r_wr_ptr);
          r_wst          <= W_FILL;
        end
        W_FILL: if (i_wr_commit) begin
          r_wr_ptr <= r_wr_ptr + PW'(1);
          r_wst    <= W_IDLE;
        end
        default: r_wst <= W_IDLE;
      endcase

      o_used_cnt <= o_used_cnt + 5'(w_grant) - 5'(w_release);

      if (w_release)   r_q_vld[r_rd_ptr] <= 1'b0;
      if (w_commit_ok) r_q_vld[r_wr_ptr] <= 1'b1;
      // One-cycle staging between queue state and the reader gives the commit-to-request gap.
      r_avail <= r_q_vld[r_rd_ptr] && !w_release;

      case (r_rstate)
        R_IDLE: if (r_avail) begin
          o_rd_req     <= 1'b1;
          o_rd_bank    <= 4'(r_rd_ptr);
          o_rd_128cnt  <= r_q_cnt[r_rd_ptr];
          o_rd_bytecnt <= r_q_byte[r_rd_ptr];
          o_rd_last    <= r_q_last[r_rd_ptr];
          r_rstate     <= R_BUSY;
`ifdef DPB_SCHED_WDOG_EN
          r_wdog       <= 32'd0;
`endif
        end
        R_BUSY: begin
`ifdef DPB_SCHED_WDOG_EN
          r_wdog <= r_wdog + 32'd1;
`endif
          if (w_release) begin
            o_rd_req <= 1'b0;
            r_rd_ptr <= r_rd_ptr + PW'(1);
            r_rstate <= R_IDLE;
            if (w_wdog_fire) begin
              o_rd_udp_rank <= 8'd0;
            end else if (o_rd_last) begin
              o_rd_udp_rank <= 8'd0;
              o_frame_cnt   <= o_frame_cnt + 8'd1;
            end else if (o_rd_udp_rank != 8'hFF) begin
              o_rd_udp_rank <= o_rd_udp_rank + 8'd1;
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase

      if (w_proto_err) o_error <= 1'b1;
    end
  end

endmodule

// File: doc/dpb_bank_scheduler.md
Name: dpb_bank_scheduler

Overview:
- Bank manager for the 2048x128 dual-port block RAM that sits between the MJPEG DPB writer and the DDR3/UDP reader.
- The RAM is split into BANK_NUM banks of 128 words each; RAM address = {bank, word}.
- Grants free banks to the writer, queues filled banks in commit order, and presents them one at a time to the reader.
- Tracks UDP packet rank within a JPEG frame and flags protocol violations.

Parameters:
- BANK_NUM, 16: number of banks; power of 2, 2..16.
- UDP_FRAME_MAX_SIZE_128, 91: maximum 128-bit words per bank/UDP packet.
- RD_TIMEOUT, 1000000: cycles allowed per read before the watchdog fires (optional feature only).

Ports:
- i_pclk  in  1  clock.
- i_rst  in  1  asynchronous reset, active-high.
- i_wr_alloc_req  in  1  writer requests a free bank; level, held until grant.
- o_wr_alloc_gnt  out  1  one-cycle pulse; bank granted.
- o_wr_bank  out  4  granted bank; valid from grant until next grant.
- i_wr_commit  in  1  one-cycle pulse; granted bank is filled.
- i_wr_commit_128cnt  in  7  words written into the bank.
- i_wr_commit_bytecnt  in  6  valid bytes in the last word (0 = all 16).
- i_wr_commit_last  in  1  bank ends a JPEG frame.
- o_rd_req  out  1  a bank is ready for the reader.
- o_rd_bank  out  4  bank to read.
- o_rd_128cnt  out  7  word count.
- o_rd_bytecnt  out  6  byte count.
- o_rd_last  out  1  frame-end bank.
- o_rd_udp_rank  out  8  packet index within the frame.
- i_rd_done  in  1  one-cycle pulse; reader finished, bank released.
- o_used_cnt  out  5  banks granted or queued.
- o_frame_cnt  out  8  frames completed by the reader (wraps).
- o_error  out  1  sticky protocol error.

Behaviour:
- Reset (async, any time, including mid-transfer):
  - All outputs 0; writer FSM to W_IDLE, reader FSM to R_IDLE.
  - Queue emptied, write and read pointers 0, all banks free.
  - Effect is immediate; no pending grant or request survives.
- Banks are allocated strictly in sequence wr_ptr = 0,1,...,BANK_NUM-1 and wrap. Release order equals allocation order, so two pointers plus o_used_cnt fully describe bank state.
- Writer FSM:
  - W_IDLE: if i_wr_alloc_req and registered o_used_cnt < BANK_NUM: pulse o_wr_alloc_gnt next cycle, o_wr_bank = wr_ptr, o_used_cnt += 1, go W_FILL. A release in the same cycle does not enable a grant; the grant waits one cycle.
  - W_FILL: on i_wr_commit, store {bank, 128cnt, bytecnt, last} in queue slot wr_ptr, wr_ptr += 1 (mod BANK_NUM), go W_IDLE.
- Reader FSM:
  - R_IDLE: if an entry is queued at rd_ptr, drive the o_rd_* fields from it and raise o_rd_req, go R_BUSY. Commit sampled at edge N gives o_rd_req high from edge N+2.
  - R_BUSY: o_rd_req held high and fields held stable until i_rd_done. Then o_rd_req = 0, rd_ptr += 1, o_used_cnt -= 1.
    - If o_rd_last: o_rd_udp_rank := 0 and o_frame_cnt += 1.
    - Else: o_rd_udp_rank += 1, saturating at 255 and setting o_error.
    - Go R_IDLE. Minimum one idle cycle between consecutive o_rd_req.
- Same-cycle grant and release: both apply and the count is net unchanged. Same-cycle commit and done: both apply.
- o_error set (sticky until reset) on any of:
  - i_wr_commit outside W_FILL (commit ignored);
  - i_rd_done outside R_BUSY (ignored);
  - i_wr_commit_128cnt = 0 or > UDP_FRAME_MAX_SIZE_128 (commit still accepted);
  - udp_rank saturation.
- i_wr_alloc_req while o_used_cnt = BANK_NUM: no grant, no error; the writer stalls.

Optional Feature:
- DPB_SCHED_WDOG_EN defined:
  - A 32-bit counter runs while in R_BUSY.
  - At RD_TIMEOUT-1 it force-releases exactly as if i_rd_done arrived, sets o_error, and resets o_rd_udp_rank to 0 so the next frame restarts at rank 0.
  - The counter clears on every entry to R_BUSY.
- Undefined: no counter; R_BUSY waits on i_rd_done indefinitely.

Test Plan:
- Single bank: alloc, commit 128cnt=91 bytecnt=0 last=1, done 5 cycles later -> gnt bank 0; o_rd_req at commit+2 with bank 0, cnt 91, rank 0; o_frame_cnt=1; o_used_cnt returns to 0.
- Frame of 3 banks (91, 91, 17/bytecnt 5 last) -> ranks 0,1,2 on banks 0,1,2; next frame's first bank has rank 0 on bank 3.
- Fill all 16 banks with the reader stalled -> 17th alloc gets no grant, o_used_cnt=16; one i_rd_done -> grant of bank 0 exactly 2 cycles after done; o_error stays 0.
- Protocol errors: commit without grant, done while R_IDLE, commit 128cnt=92 -> o_error=1 each time, queue contents unchanged for the ignored events.
- Async i_rst pulse while in R_BUSY with 5 banks queued -> all outputs 0 immediately; the next alloc is granted bank 0.
- DPB_SCHED_WDOG_EN with RD_TIMEOUT=100, i_rd_done never asserted -> o_rd_req drops after 100 cycles, o_error=1, next bank presented with rank 0.
